// File: rtl/riscv_rf_pkg.sv
// Shared constants, types and helpers for the register-bank write-back path.
package riscv_rf_pkg;

  localparam int REG_N     = 32;
  localparam int XLEN      = 64;
  localparam int REG_PTR_W = $clog2(REG_N);
  localparam logic [REG_PTR_W-1:0] X0 = '0;

  typedef logic [REG_PTR_W-1:0] reg_ptr_t;
  typedef logic [XLEN-1:0]      xlen_t;

  // One pending write-back: destination register and its value.
  typedef struct packed {
    reg_ptr_t rd;
    xlen_t    data;
  } wb_req_t;

  // Successor of a requester index in a ring of n requesters.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/regfile_wb_sched_if.sv
// Bundle of write-back request, issue/scoreboard and bank-write signals.
// Optional forwarding outputs byp1/byp2 exist only when WB_BYPASS_EN is defined.
interface regfile_wb_sched_if
  import riscv_rf_pkg::*;
#(
  parameter int N    = REG_N,
  parameter int Bits = XLEN,
  parameter int NREQ = 2
);
  localparam int PW = $clog2(N);

  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*PW-1:0]   req_rd;
  logic [NREQ*Bits-1:0] req_data;
  logic                 issue_en;
  logic [PW-1:0]        issue_rd;
  logic                 issue_ready;
  logic [PW-1:0]        rs1;
  logic [PW-1:0]        rs2;
  logic                 hazard;
  logic [PW-1:0]        ptr_wr;
  logic [Bits-1:0]      data_wr;
  logic                 wr_en;
`ifdef WB_BYPASS_EN
  logic                 byp1;
  logic                 byp2;
`endif

  // Pipeline / bank side: drives requests and decode info, observes results.
  modport master (
    output req_valid, req_rd, req_data, issue_en, issue_rd, rs1, rs2,
    input  req_ready, issue_ready, hazard, ptr_wr, data_wr, wr_en
`ifdef WB_BYPASS_EN
    , input byp1, byp2
`endif
  );

  // Scheduler side.
  modport slave (
    input  req_valid, req_rd, req_data, issue_en, issue_rd, rs1, rs2,
    output req_ready, issue_ready, hazard, ptr_wr, data_wr, wr_en
`ifdef WB_BYPASS_EN
    , output byp1, byp2
`endif
  );

endinterface

// File: rtl/regfile_wb_sched_rr_arbiter.sv
// Round-robin arbiter: search starts at rr_ptr, grant moves the pointer past the winner.
module rr_arbiter
  import riscv_rf_pkg::*;
#(
  parameter int NREQ = 2,
  localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_idx,
  output logic            grant_any
);

  logic [IW-1:0] rr_ptr_q;
  logic [IW-1:0] rr_ptr_d;

  // Pick the first asserted request at or after rr_ptr; walk backwards so the closest wins.
  always_comb begin
    int idx;
    idx       = 0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr_q) + k) % NREQ;
      if (req[idx]) begin
        grant_idx = IW'(idx);
        grant_any = 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_grant
      assign grant[gi] = grant_any && (grant_idx == IW'(gi));
    end
  endgenerate

  // Pointer advances only on a grant.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_any) rr_ptr_d = IW'(rr_next(int'(grant_idx), NREQ));
  end

  // Pointer register, back to requester 0 on reset.
  always_ff @(posedge clk) begin
    if (!rst) rr_ptr_q <= '0;
    else      rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/regfile_wb_sched.sv
// Write-back scheduler and hazard scoreboard in front of the register bank's
// single write port. Define WB_BYPASS_EN to add byp1/byp2 forwarding flags
// that let decode proceed during the commit cycle.
module regfile_wb_sched
  import riscv_rf_pkg::*;
#(
  parameter int N    = REG_N,
  parameter int Bits = XLEN,
  parameter int NREQ = 2
) (
  input logic               clk,
  input logic               rst,
  regfile_wb_sched_if.slave bus
);

  localparam int PW = $clog2(N);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0] grant;
  logic [IW-1:0]   grant_idx;
  logic            grant_any;

  logic [PW-1:0]   req_rd_arr   [NREQ];
  logic [Bits-1:0] req_data_arr [NREQ];
  logic [PW-1:0]   sel_rd;
  logic [Bits-1:0] sel_data;

  logic            wr_en_q, wr_en_d;
  logic [PW-1:0]   ptr_wr_q, ptr_wr_d;
  logic [Bits-1:0] data_wr_q, data_wr_d;
  logic [N-1:0]    busy_q, busy_d;

  logic            match1, match2;
  logic            fwd1, fwd2;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (bus.req_valid),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign bus.req_ready = grant;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign req_rd_arr[gi]   = bus.req_rd[gi*PW +: PW];
      assign req_data_arr[gi] = bus.req_data[gi*Bits +: Bits];
    end
  endgenerate

  assign sel_rd   = req_rd_arr[grant_idx];
  assign sel_data = req_data_arr[grant_idx];

  // Register the granted write; x0 grants are accepted but never reach the bank.
  always_comb begin
    wr_en_d   = grant_any && (sel_rd != '0);
    ptr_wr_d  = ptr_wr_q;
    data_wr_d = data_wr_q;
    if (wr_en_d) begin
      ptr_wr_d  = sel_rd;
      data_wr_d = sel_data;
    end
  end

  // Scoreboard update: the commit clears first, then a new issue sets, so set wins on a tie.
  always_comb begin
    busy_d = busy_q;
    if (wr_en_q) busy_d[ptr_wr_q] = 1'b0;
    if (bus.issue_en && bus.issue_ready && (bus.issue_rd != '0)) busy_d[bus.issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Write-stage and scoreboard registers; reset drops any registered write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_en_q   <= 1'b0;
      ptr_wr_q  <= '0;
      data_wr_q <= '0;
      busy_q    <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      ptr_wr_q  <= ptr_wr_d;
      data_wr_q <= data_wr_d;
      busy_q    <= busy_d;
    end
  end

  // A register may be re-issued only if idle or retiring its write this cycle.
  always_comb begin
    bus.issue_ready = !busy_q[bus.issue_rd] || (wr_en_q && (ptr_wr_q == bus.issue_rd));
  end

  // Source hazard detection, optionally masked by same-cycle forwarding of data_wr.
  always_comb begin
    match1 = (bus.rs1 != '0) && busy_q[bus.rs1];
    match2 = (bus.rs2 != '0) && busy_q[bus.rs2];
    fwd1   = wr_en_q && (ptr_wr_q == bus.rs1) && (bus.rs1 != '0);
    fwd2   = wr_en_q && (ptr_wr_q == bus.rs2) && (bus.rs2 != '0);
`ifdef WB_BYPASS_EN
    bus.hazard = (match1 && !fwd1) || (match2 && !fwd2);
`else
    bus.hazard = match1 || match2;
`endif
  end

`ifdef WB_BYPASS_EN
  assign bus.byp1 = fwd1;
  assign bus.byp2 = fwd2;
`else
  logic unused_fwd;
  assign unused_fwd = fwd1 ^ fwd2;
`endif

  assign bus.wr_en   = wr_en_q;
  assign bus.ptr_wr  = ptr_wr_q;
  assign bus.data_wr = data_wr_q;

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Self-checking bench for regfile_wb_sched: table of arbitration/scoreboard
// vectors plus hand sequences for hazard lifecycle, set/clear tie, x0 and reset.
module tb_regfile_wb_sched;
  import riscv_rf_pkg::*;

  localparam int NREQ = 2;
`ifdef WB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  regfile_wb_sched_if #(.N(REG_N), .Bits(XLEN), .NREQ(NREQ)) bus ();

  regfile_wb_sched #(.N(REG_N), .Bits(XLEN), .NREQ(NREQ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic    en;
    wb_req_t wr;
  } exp_wr_t;
  exp_wr_t exp_q[$];

  reg_ptr_t rd_v [NREQ];
  xlen_t    d_v  [NREQ];

  typedef struct {
    logic [1:0] valid;
    reg_ptr_t   rd0;
    xlen_t      d0;
    reg_ptr_t   rd1;
    xlen_t      d1;
    logic       ien;
    reg_ptr_t   ird;
    reg_ptr_t   rs1;
    reg_ptr_t   rs2;
    logic [1:0] exp_ready;
    logic       exp_iready;
    logic       exp_haz;
  } vec_t;
  vec_t tbl [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive();
    bus.req_rd   = {rd_v[1], rd_v[0]};
    bus.req_data = {d_v[1], d_v[0]};
  endtask

  // Advance one clock and compare the bank write against the scoreboard head.
  task automatic tick(input string tag);
    exp_wr_t e;
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check({tag, " wr_en"}, 64'(bus.wr_en), 64'(e.en));
    if (e.en) begin
      check({tag, " ptr_wr"}, 64'(bus.ptr_wr), 64'(e.wr.rd));
      check({tag, " data_wr"}, 64'(bus.data_wr), 64'(e.wr.data));
    end
    $display("[%0t] %s: wr_en=%0b ptr_wr=%0d data_wr=0x%0h hazard=%0b",
             $time, tag, bus.wr_en, bus.ptr_wr, bus.data_wr, bus.hazard);
  endtask

  // Apply current inputs for one cycle; check combinational outputs and queue the expected write.
  task automatic cycle(input string tag, input logic [1:0] exp_ready,
                       input logic exp_iready, input logic exp_haz, input logic chk);
    exp_wr_t e;
    drive();
    #1;
    if (chk) begin
      check({tag, " req_ready"}, 64'(bus.req_ready), 64'(exp_ready));
      check({tag, " issue_ready"}, 64'(bus.issue_ready), 64'(exp_iready));
      check({tag, " hazard"}, 64'(bus.hazard), 64'(exp_haz));
    end
    e = '0;
    if (rst) begin
      if (exp_ready[0]) begin
        e.wr.rd = rd_v[0]; e.wr.data = d_v[0]; e.en = (rd_v[0] != X0);
      end else if (exp_ready[1]) begin
        e.wr.rd = rd_v[1]; e.wr.data = d_v[1]; e.en = (rd_v[1] != X0);
      end
    end
    exp_q.push_back(e);
    tick(tag);
  endtask

  task automatic idle_inputs();
    bus.req_valid = '0;
    bus.issue_en  = 1'b0;
    bus.issue_rd  = '0;
    bus.rs1       = '0;
    bus.rs2       = '0;
    rd_v[0] = '0; rd_v[1] = '0;
    d_v[0]  = '0; d_v[1]  = '0;
  endtask

  initial begin
    tbl[0] = '{2'b00, 5'd0, 64'h0,    5'd0, 64'h0,  1'b0, 5'd3, 5'd0, 5'd0, 2'b00, 1'b1, 1'b0};
    tbl[1] = '{2'b01, 5'd5, 64'hDEAD, 5'd0, 64'h0,  1'b0, 5'd5, 5'd5, 5'd0, 2'b01, 1'b1, 1'b0};
    tbl[2] = '{2'b10, 5'd0, 64'h0,    5'd2, 64'h22, 1'b0, 5'd0, 5'd0, 5'd0, 2'b10, 1'b1, 1'b0};
    tbl[3] = '{2'b11, 5'd3, 64'hA0,   5'd7, 64'hB1, 1'b1, 5'd9, 5'd0, 5'd0, 2'b01, 1'b1, 1'b0};
    tbl[4] = '{2'b11, 5'd3, 64'hA0,   5'd7, 64'hB1, 1'b0, 5'd9, 5'd9, 5'd0, 2'b10, 1'b0, 1'b1};
    tbl[5] = '{2'b11, 5'd3, 64'hA0,   5'd7, 64'hB1, 1'b0, 5'd9, 5'd0, 5'd9, 2'b01, 1'b0, 1'b1};
    tbl[6] = '{2'b11, 5'd3, 64'hA0,   5'd7, 64'hB1, 1'b1, 5'd0, 5'd0, 5'd0, 2'b10, 1'b1, 1'b0};

    // Reset with inputs toggling.
    idle_inputs();
    rst = 1'b0;
    bus.req_valid = 2'b11; rd_v[0] = 5'd5; rd_v[1] = 5'd6; d_v[0] = 64'h11; d_v[1] = 64'h22;
    bus.issue_en = 1'b1; bus.issue_rd = 5'd5; bus.rs1 = 5'd5; bus.rs2 = 5'd6;
    cycle("reset0", 2'b00, 1'b0, 1'b0, 1'b0);
    bus.req_valid = 2'b10; bus.issue_en = 1'b0; bus.rs1 = 5'd6;
    cycle("reset1", 2'b00, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    idle_inputs();
    bus.issue_rd = 5'd5; bus.rs1 = 5'd5; bus.rs2 = 5'd6;
    drive();
    #1;
    check("reset wr_en", 64'(bus.wr_en), 64'd0);
    check("reset ptr_wr", 64'(bus.ptr_wr), 64'd0);
    check("reset data_wr", 64'(bus.data_wr), 64'd0);
    check("reset hazard", 64'(bus.hazard), 64'd0);
    check("reset issue_ready", 64'(bus.issue_ready), 64'd1);

    // Table: idle, single write, fairness, busy/hazard basics.
    for (int i = 0; i < 7; i++) begin
      bus.req_valid = tbl[i].valid;
      rd_v[0] = tbl[i].rd0; d_v[0] = tbl[i].d0;
      rd_v[1] = tbl[i].rd1; d_v[1] = tbl[i].d1;
      bus.issue_en = tbl[i].ien; bus.issue_rd = tbl[i].ird;
      bus.rs1 = tbl[i].rs1; bus.rs2 = tbl[i].rs2;
      cycle($sformatf("vec%0d", i), tbl[i].exp_ready, tbl[i].exp_iready, tbl[i].exp_haz, 1'b1);
    end

    // Hazard lifecycle on x9 (busy from the table).
    idle_inputs();
    bus.req_valid = 2'b01; rd_v[0] = 5'd9; d_v[0] = 64'h99;
    bus.rs1 = 5'd9; bus.issue_rd = 5'd9;
    cycle("A grant", 2'b01, 1'b0, 1'b1, 1'b1);
    bus.req_valid = 2'b00;
`ifdef WB_BYPASS_EN
    drive(); #1;
    check("A byp1", 64'(bus.byp1), 64'd1);
`endif
    cycle("A commit", 2'b00, 1'b1, !BYP, 1'b1);
    cycle("A after", 2'b00, 1'b1, 1'b0, 1'b1);

    // Same-index set and clear on x9.
    idle_inputs();
    bus.issue_en = 1'b1; bus.issue_rd = 5'd9;
    cycle("B issue", 2'b00, 1'b1, 1'b0, 1'b1);
    bus.issue_en = 1'b0;
    bus.req_valid = 2'b10; rd_v[1] = 5'd9; d_v[1] = 64'h1234_5678_9ABC_DEF0;
    cycle("B grant", 2'b10, 1'b0, 1'b0, 1'b1);
    bus.req_valid = 2'b00; bus.issue_en = 1'b1; bus.rs2 = 5'd9;
`ifdef WB_BYPASS_EN
    drive(); #1;
    check("B byp2", 64'(bus.byp2), 64'd1);
`endif
    cycle("B tie", 2'b00, 1'b1, !BYP, 1'b1);
    bus.issue_en = 1'b0;
    cycle("B still busy", 2'b00, 1'b0, 1'b1, 1'b1);
    bus.req_valid = 2'b01; rd_v[0] = 5'd9; d_v[0] = 64'h55;
    cycle("B clear grant", 2'b01, 1'b0, 1'b1, 1'b1);
    bus.req_valid = 2'b00;
    cycle("B clear commit", 2'b00, 1'b1, !BYP, 1'b1);
    cycle("B cleared", 2'b00, 1'b1, 1'b0, 1'b1);

    // x0 write is accepted but never reaches the bank.
    idle_inputs();
    bus.req_valid = 2'b10; rd_v[1] = 5'd0; d_v[1] = 64'hFF;
    cycle("C x0", 2'b10, 1'b1, 1'b0, 1'b1);
    bus.req_valid = 2'b00;
    cycle("C x0 idle", 2'b00, 1'b1, 1'b0, 1'b1);

    // Reset while a write is registered.
    bus.issue_en = 1'b1; bus.issue_rd = 5'd4;
    cycle("D issue", 2'b00, 1'b1, 1'b0, 1'b1);
    bus.issue_en = 1'b0; bus.rs1 = 5'd4;
    bus.req_valid = 2'b01; rd_v[0] = 5'd4; d_v[0] = 64'h44;
    cycle("D grant", 2'b01, 1'b0, 1'b1, 1'b1);
    rst = 1'b0; bus.req_valid = 2'b00;
    cycle("D reset", 2'b00, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    drive(); #1;
    check("D ptr_wr", 64'(bus.ptr_wr), 64'd0);
    check("D data_wr", 64'(bus.data_wr), 64'd0);
    cycle("D after", 2'b00, 1'b1, 1'b0, 1'b1);
    bus.rs1 = 5'd0;
    bus.req_valid = 2'b11; rd_v[0] = 5'd6; d_v[0] = 64'h66; rd_v[1] = 5'd8; d_v[1] = 64'h88;
    cycle("D rr", 2'b01, 1'b1, 1'b0, 1'b1);
    bus.req_valid = 2'b10;
    cycle("D rr2", 2'b10, 1'b1, 1'b0, 1'b1);
    bus.req_valid = 2'b00;
    cycle("drain", 2'b00, 1'b1, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_wb_sched.md
Name: regfile_wb_sched

Overview:
Write-back scheduler and hazard scoreboard for the RISC-V register bank.
- Arbitrates NREQ write-back sources (ALU, load unit, multi-cycle unit) onto the bank's single write port (ptr_wr/data_wr/wr_en) with round-robin fairness.
- Tracks registers with writes in flight and raises a read-hazard stall toward decode.
- Sits between the execute/memory stages and the register bank.

Parameters:
N, 32, number of architectural registers (x0 hardwired zero)
Bits, 64, register data width
NREQ, 2, number of write-back requesters (2..4)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; synchronous, active-low
req_valid  in  NREQ  requester i holds a write-back
req_ready  out  NREQ  requester i accepted this cycle (combinational from grant)
req_rd  in  NREQ*$clog2(N)  destination pointer, requester i in slice i
req_data  in  NREQ*Bits  write data, requester i in slice i
issue_en  in  1  decode issues an instruction that will write issue_rd
issue_rd  in  $clog2(N)  destination of the issuing instruction
issue_ready  out  1  issue_rd may be marked in-flight this cycle
rs1, rs2  in  $clog2(N) each  source pointers of the instruction in decode
hazard  out  1  rs1 or rs2 has a pending write; decode must stall
ptr_wr  out  $clog2(N)  to bank write pointer
data_wr  out  Bits  to bank write data
wr_en  out  1  to bank write enable

Behaviour:
- Reset (rst=0 at clk edge):
  - wr_en=0, ptr_wr=0, data_wr=0.
  - All busy bits cleared.
  - Round-robin pointer = requester 0.
  - Reset mid-transfer drops the registered write.
- Arbitration:
  - Round-robin among asserted req_valid, starting at rr_ptr.
  - Exactly one req_ready is high per cycle when any req_valid is high; none otherwise.
  - On grant to i, rr_ptr <= (i+1) mod NREQ; otherwise rr_ptr holds.
  - Requesters hold valid/rd/data stable until ready.
- Write stage:
  - Granted rd/data are registered; wr_en=1 in cycle t+1 after grant at t.
  - Latency is 1 cycle; the bank commits at the end of t+1.
  - Throughput is one write per cycle.
- x0:
  - A grant with req_rd=0 is accepted (ready=1).
  - wr_en stays 0 for it and no busy bit is touched.
- Scoreboard (busy[N-1:0], busy[0] always 0):
  - Set: issue_en && issue_ready && issue_rd!=0 sets busy[issue_rd].
  - Clear: wr_en=1 clears busy[ptr_wr] at the end of that cycle.
  - issue_ready = !busy[issue_rd] || (wr_en && ptr_wr==issue_rd). This forbids two outstanding writes to one register.
  - Simultaneous set and clear of the same index: set wins, so the bit stays 1.
- hazard = (rs1!=0 && busy[rs1]) || (rs2!=0 && busy[rs2]). It is combinational from state.
- Write-back for a non-busy register: performed normally. No error is flagged.

Optional Feature:
Macro WB_BYPASS_EN.
- Defined:
  - Adds outputs byp1, byp2 (1 bit each), asserted when wr_en && ptr_wr==rsX && rsX!=0.
  - hazard masks those matches, so decode proceeds with data_wr forwarded in the commit cycle.
- Undefined:
  - Ports absent.
  - hazard stays high through the commit cycle and drops the cycle after.

Decomposition:
- Package riscv_rf_pkg:
  - Constants: REG_N=32, XLEN=64, REG_PTR_W=$clog2(REG_N), X0=0.
  - Typedefs: reg_ptr_t, xlen_t.
  - The wb_req_t struct {rd, data}.
- One sub-module, rr_arbiter #(NREQ): request vector in; one-hot grant plus index out; owns rr_ptr with the same clk and active-low synchronous rst.

Test Plan:
1. Reset and idle: assert rst=0 for 2 cycles with all inputs toggling → wr_en=0, hazard=0, issue_ready=1, ptr_wr=0, data_wr=0.
2. Single write: req0 rd=5, data=0xDEAD at t → req_ready[0]=1 at t; wr_en=1, ptr_wr=5, data_wr=0xDEAD at t+1.
3. Fairness: both requesters continuously valid for 4 cycles (rd=3, rd=7) → grants alternate 0,1,0,1; wr_en high 4 consecutive cycles.
4. Hazard lifecycle: issue rd=9; then rs1=9 → hazard=1 until the commit of rd=9; hazard=0 the cycle after commit (0 during the commit cycle with WB_BYPASS_EN, byp1=1).
5. Same-index set/clear: busy[9] set, write-back of 9 committing while issue_en rd=9 → issue_ready=1, busy[9] remains 1, hazard on rs2=9 the next cycle.
6. x0 and mid-op reset: req rd=0 data=0xFF → ready=1, wr_en never high. Grant rd=4, then rst=0 at t+1 → wr_en=0 at t+2 and busy cleared.
